// File: rtl/lp_esc_receiver.sv
// LP escape-mode receiver for one D-PHY data lane.
// Synchronizes and glitch-filters the Dp/Dn pair, follows the LP state
// sequence, and decodes the escape entry command, LPDT bytes, ULPS and
// reset-trigger.
// Optional build macro: LP_TIMEOUT_EN adds an idle-line watchdog that
// aborts a stalled escape sequence after TIMEOUT_CYC cycles.
//
// state        | meaning
// -------------+-----------------------------------------------------
// ST_STOP      | idle, line LP-11
// ST_ESC1      | LP-10 seen, first step of escape entry
// ST_ESC2      | LP-00 seen after LP-10
// ST_ESC3      | LP-01 seen, waiting for the space that starts the command
// ST_SPACE     | LP-00 between marks
// ST_MARK1     | LP-10 mark (bit 1, or exit mark when followed by LP-11)
// ST_MARK0     | LP-01 mark (bit 0)
// ST_HSWAIT    | HS request seen, waiting for LP-11
// ST_WAIT_STOP | after a protocol error, waiting for LP-11
module lp_esc_receiver #(
  parameter int FILT_CYC    = 4,
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic       i_CLK_100MHZ,
  input  logic       i_reset,
  input  logic       i_lp_p,
  input  logic       i_lp_n,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic [7:0] o_cmd,
  output logic       o_cmd_valid,
  output logic       o_lpdt_active,
  output logic       o_ulps_active,
  output logic       o_trigger,
  output logic       o_stop_state,
  output logic       o_err_esc,
  output logic       o_err_sync
);

  typedef enum logic [3:0] {
    ST_STOP, ST_ESC1, ST_ESC2, ST_ESC3, ST_SPACE,
    ST_MARK1, ST_MARK0, ST_HSWAIT, ST_WAIT_STOP
  } state_t;

  typedef enum logic [1:0] {PH_CMD, PH_LPDT, PH_ULPS, PH_IGNORE} phase_t;

  logic [1:0] sync1, sync2;
  logic [1:0] line_f, cand;
  logic [3:0] filt_cnt;
  logic [4:0] filt_cnt_inc;
  logic       f_chg;

  state_t     state, state_n;
  phase_t     phase, phase_n;
  logic [2:0] bit_cnt, cnt_n;
  logic [7:0] shreg, sh_n;
  logic [7:0] data_n, cmd_n, rx_byte;
  logic       lpdt_n, ulps_n, rxv_n, cmdv_n, trig_n, erre_n, errs_n;
  logic       commit, bit_val, abort;
  logic       to_hit;

  // Two-flop synchronizer; the idle line is LP-11
  always_ff @(posedge i_CLK_100MHZ or posedge i_reset) begin
    if (i_reset) begin
      sync1 <= 2'b11;
      sync2 <= 2'b11;
    end else begin
      sync1 <= {i_lp_p, i_lp_n};
      sync2 <= sync1;
    end
  end

  // A new value must be seen on FILT_CYC consecutive samples; a different
  // mismatching value restarts the count with itself as the candidate.
  assign filt_cnt_inc = (sync2 == cand) ? ({1'b0, filt_cnt} + 5'd1) : 5'd1;

  // Glitch filter producing the line state the FSM acts on
  always_ff @(posedge i_CLK_100MHZ or posedge i_reset) begin
    if (i_reset) begin
      line_f   <= 2'b11;
      cand     <= 2'b11;
      filt_cnt <= 4'd0;
      f_chg    <= 1'b0;
    end else begin
      f_chg <= 1'b0;
      if (sync2 == line_f) begin
        filt_cnt <= 4'd0;
      end else if (filt_cnt_inc >= 5'(FILT_CYC)) begin
        line_f   <= sync2;
        cand     <= sync2;
        filt_cnt <= 4'd0;
        f_chg    <= 1'b1;
      end else begin
        cand     <= sync2;
        filt_cnt <= filt_cnt_inc[3:0];
      end
    end
  end

`ifdef LP_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_cnt;
  logic          to_clr;

  assign to_clr = f_chg || (state == ST_STOP) || (state == ST_HSWAIT) || o_ulps_active;
  assign to_hit = !to_clr && (to_cnt == TW'(TIMEOUT_CYC - 1));

  // Idle-line watchdog; restarts on any line activity or in the resting states
  always_ff @(posedge i_CLK_100MHZ or posedge i_reset) begin
    if (i_reset) begin
      to_cnt <= '0;
    end else if (to_clr || to_hit) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  // Watchdog compiled out; the FSM waits on the line indefinitely
  assign to_hit = 1'b0 & (TIMEOUT_CYC != 0);
`endif

  // Next-state, bit assembly and output pulse decode
  always_comb begin
    state_n = state;
    phase_n = phase;
    cnt_n   = bit_cnt;
    sh_n    = shreg;
    data_n  = o_rx_data;
    cmd_n   = o_cmd;
    lpdt_n  = o_lpdt_active;
    ulps_n  = o_ulps_active;
    rxv_n   = 1'b0;
    cmdv_n  = 1'b0;
    trig_n  = 1'b0;
    erre_n  = 1'b0;
    errs_n  = 1'b0;
    commit  = 1'b0;
    bit_val = 1'b0;
    abort   = 1'b0;
    rx_byte = 8'd0;

    if (f_chg) begin
      case (state)
        ST_STOP: begin
          case (line_f)
            2'b10: state_n = ST_ESC1;
            2'b01: state_n = ST_HSWAIT;
            2'b00: begin state_n = ST_WAIT_STOP; erre_n = 1'b1; end
            default: ;
          endcase
        end
        ST_ESC1: begin
          case (line_f)
            2'b00: state_n = ST_ESC2;
            2'b11: state_n = ST_STOP;
            default: begin state_n = ST_WAIT_STOP; erre_n = 1'b1; end
          endcase
        end
        ST_ESC2: begin
          case (line_f)
            2'b01: state_n = ST_ESC3;
            2'b11: state_n = ST_STOP;
            default: begin state_n = ST_WAIT_STOP; erre_n = 1'b1; end
          endcase
        end
        ST_ESC3: begin
          case (line_f)
            2'b00: begin state_n = ST_SPACE; phase_n = PH_CMD; cnt_n = 3'd0; end
            2'b11: state_n = ST_STOP;
            default: begin state_n = ST_WAIT_STOP; erre_n = 1'b1; end
          endcase
        end
        ST_SPACE: begin
          case (line_f)
            2'b10: state_n = ST_MARK1;
            2'b01: begin
              if (phase == PH_ULPS) begin
                state_n = ST_WAIT_STOP;
                erre_n  = 1'b1;
                abort   = 1'b1;
              end else begin
                state_n = ST_MARK0;
              end
            end
            default: begin
              // LP-11 straight from a space is not a proper exit
              state_n = ST_STOP;
              abort   = 1'b1;
              if (bit_cnt != 3'd0) errs_n = 1'b1;
              else                 erre_n = 1'b1;
            end
          endcase
        end
        ST_MARK1: begin
          case (line_f)
            2'b00: begin commit = 1'b1; bit_val = 1'b1; state_n = ST_SPACE; end
            2'b11: begin
              state_n = ST_STOP;
              abort   = 1'b1;
              errs_n  = (bit_cnt != 3'd0);
            end
            default: begin state_n = ST_WAIT_STOP; erre_n = 1'b1; abort = 1'b1; end
          endcase
        end
        ST_MARK0: begin
          case (line_f)
            2'b00: begin commit = 1'b1; bit_val = 1'b0; state_n = ST_SPACE; end
            2'b11: begin state_n = ST_STOP; erre_n = 1'b1; abort = 1'b1; end
            default: begin state_n = ST_WAIT_STOP; erre_n = 1'b1; abort = 1'b1; end
          endcase
        end
        ST_HSWAIT, ST_WAIT_STOP: begin
          if (line_f == 2'b11) state_n = ST_STOP;
        end
        default: state_n = ST_WAIT_STOP;
      endcase
    end

    if (commit) begin
      sh_n[bit_cnt] = bit_val;
      cnt_n         = bit_cnt + 3'd1;
      if (bit_cnt == 3'd7) begin
        rx_byte = sh_n;
        case (phase)
          PH_CMD: begin
            cmd_n  = rx_byte;
            cmdv_n = 1'b1;
            case (rx_byte)
              8'h87: begin phase_n = PH_LPDT; lpdt_n = 1'b1; end
              8'h78: begin phase_n = PH_ULPS; ulps_n = 1'b1; end
              8'h46: begin phase_n = PH_IGNORE; trig_n = 1'b1; end
              default: phase_n = PH_IGNORE;
            endcase
          end
          PH_LPDT: begin
            data_n = rx_byte;
            rxv_n  = 1'b1;
          end
          default: ;
        endcase
      end
    end

    if (to_hit) begin
      state_n = ST_WAIT_STOP;
      erre_n  = 1'b1;
      abort   = 1'b1;
    end

    if (abort) begin
      lpdt_n = 1'b0;
      ulps_n = 1'b0;
      cnt_n  = 3'd0;
      sh_n   = 8'd0;
    end
  end

  // FSM, shift register and registered outputs
  always_ff @(posedge i_CLK_100MHZ or posedge i_reset) begin
    if (i_reset) begin
      state         <= ST_STOP;
      phase         <= PH_CMD;
      bit_cnt       <= 3'd0;
      shreg         <= 8'd0;
      o_rx_data     <= 8'd0;
      o_rx_valid    <= 1'b0;
      o_cmd         <= 8'd0;
      o_cmd_valid   <= 1'b0;
      o_lpdt_active <= 1'b0;
      o_ulps_active <= 1'b0;
      o_trigger     <= 1'b0;
      o_err_esc     <= 1'b0;
      o_err_sync    <= 1'b0;
    end else begin
      state         <= state_n;
      phase         <= phase_n;
      bit_cnt       <= cnt_n;
      shreg         <= sh_n;
      o_rx_data     <= data_n;
      o_rx_valid    <= rxv_n;
      o_cmd         <= cmd_n;
      o_cmd_valid   <= cmdv_n;
      o_lpdt_active <= lpdt_n;
      o_ulps_active <= ulps_n;
      o_trigger     <= trig_n;
      o_err_esc     <= erre_n;
      o_err_sync    <= errs_n;
    end
  end

  assign o_stop_state = (state == ST_STOP) && (line_f == 2'b11);

endmodule

// File: tb/tb_lp_esc_receiver.sv
// Testbench for lp_esc_receiver: drives LP line sequences built from
// escape-mode rules and compares the collected output events against
// the expected command/data/error events for each scenario.
module tb_lp_esc_receiver;
  localparam int FILT = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lp_p = 1'b1;
  logic       lp_n = 1'b1;
  logic [7:0] rx_data, cmd;
  logic       rx_valid, cmd_valid, lpdt_active, ulps_active, trigger;
  logic       stop_state, err_esc, err_sync;

  lp_esc_receiver #(.FILT_CYC(FILT)) dut (
    .i_CLK_100MHZ (clk),
    .i_reset      (rst),
    .i_lp_p       (lp_p),
    .i_lp_n       (lp_n),
    .o_rx_data    (rx_data),
    .o_rx_valid   (rx_valid),
    .o_cmd        (cmd),
    .o_cmd_valid  (cmd_valid),
    .o_lpdt_active(lpdt_active),
    .o_ulps_active(ulps_active),
    .o_trigger    (trigger),
    .o_stop_state (stop_state),
    .o_err_esc    (err_esc),
    .o_err_sync   (err_sync)
  );

  always #5 clk = ~clk;

  // observed events
  logic [7:0] rxq[$];
  logic [7:0] cmdq[$];
  int n_trig, n_err_esc, n_err_sync, n_not_stop;

  // expected events
  logic [7:0] exp_rx[$];
  logic [7:0] exp_cmd[$];
  int exp_trig, exp_esc, exp_sync;

  int n_checks = 0;
  int n_fail   = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid)   rxq.push_back(rx_data);
      if (cmd_valid)  cmdq.push_back(cmd);
      if (trigger)    n_trig++;
      if (err_esc)    n_err_esc++;
      if (err_sync)   n_err_sync++;
      if (!stop_state) n_not_stop++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic int hold();
    return FILT + 6 + int'($urandom_range(0, 4));
  endfunction

  task automatic drive(input logic [1:0] v, input int n);
    {lp_p, lp_n} = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic entry();
    drive(2'b10, hold());
    drive(2'b00, hold());
    drive(2'b01, hold());
    drive(2'b00, hold());
  endtask

  task automatic send_bit(input logic b);
    drive(b ? 2'b10 : 2'b01, hold());
    drive(2'b00, hold());
  endtask

  task automatic send_byte(input logic [7:0] d);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
  endtask

  task automatic exit_mark1();
    drive(2'b10, hold());
    drive(2'b11, hold());
  endtask

  task automatic clear_all();
    rxq.delete(); cmdq.delete(); exp_rx.delete(); exp_cmd.delete();
    n_trig = 0; n_err_esc = 0; n_err_sync = 0; n_not_stop = 0;
    exp_trig = 0; exp_esc = 0; exp_sync = 0;
  endtask

  task automatic compare_all(input string tag);
    chk($sformatf("%s cmd count", tag), cmdq.size(), exp_cmd.size());
    for (int i = 0; i < exp_cmd.size() && i < cmdq.size(); i++)
      chk($sformatf("%s cmd[%0d]", tag, i), cmdq[i], exp_cmd[i]);
    chk($sformatf("%s rx count", tag), rxq.size(), exp_rx.size());
    for (int i = 0; i < exp_rx.size() && i < rxq.size(); i++)
      chk($sformatf("%s rx[%0d]", tag, i), rxq[i], exp_rx[i]);
    chk($sformatf("%s trigger count", tag), n_trig, exp_trig);
    chk($sformatf("%s err_esc count", tag), n_err_esc, exp_esc);
    chk($sformatf("%s err_sync count", tag), n_err_sync, exp_sync);
    chk($sformatf("%s stop_state", tag), stop_state, 1);
    clear_all();
  endtask

  initial begin
    logic [7:0] c, d;
    int nb;
    clear_all();
    repeat (3) @(posedge clk);
    #1;
    chk("reset outputs", {rx_data, rx_valid, cmd, cmd_valid, lpdt_active, ulps_active,
                          trigger, stop_state, err_esc, err_sync}, 24'h000004);
    rst = 1'b0;
    drive(2'b11, 5);
    chk("idle stop_state", stop_state, 1);

    // LPDT entry with command 0x87, then two data bytes
    entry();
    send_byte(8'h87);
    exp_cmd.push_back(8'h87);
    chk("lpdt active after 0x87", lpdt_active, 1);
    send_byte(8'hA5); exp_rx.push_back(8'hA5);
    send_byte(8'h3C); exp_rx.push_back(8'h3C);
    chk("lpdt active before exit", lpdt_active, 1);
    exit_mark1();
    chk("lpdt cleared on exit", lpdt_active, 0);
    compare_all("lpdt A5 3C");

    // ULPS entry held for 5000 cycles
    entry();
    send_byte(8'h78);
    exp_cmd.push_back(8'h78);
    chk("ulps active", ulps_active, 1);
    drive(2'b00, 2500);
    chk("ulps active mid hold", ulps_active, 1);
    drive(2'b00, 2500);
    chk("ulps active end hold", ulps_active, 1);
    exit_mark1();
    chk("ulps cleared on exit", ulps_active, 0);
    compare_all("ulps");

    // randomized commands and payloads
    for (int it = 0; it < 8; it++) begin
      case ($urandom_range(0, 3))
        0: c = 8'h87;
        1: c = 8'h78;
        2: c = 8'h46;
        default: c = 8'($urandom);
      endcase
      entry();
      send_byte(c);
      exp_cmd.push_back(c);
      if (c == 8'h46) exp_trig = 1;
      chk($sformatf("rand%0d lpdt level", it), lpdt_active, (c == 8'h87) ? 1 : 0);
      chk($sformatf("rand%0d ulps level", it), ulps_active, (c == 8'h78) ? 1 : 0);
      if (c != 8'h78) begin
        nb = int'($urandom_range(0, 3));
        for (int k = 0; k < nb; k++) begin
          d = 8'($urandom);
          send_byte(d);
          if (c == 8'h87) exp_rx.push_back(d);
        end
      end
      exit_mark1();
      chk($sformatf("rand%0d levels after exit", it), {lpdt_active, ulps_active}, 0);
      compare_all($sformatf("rand%0d", it));
    end

    // exit with a partial byte
    entry();
    send_byte(8'h87);
    exp_cmd.push_back(8'h87);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    exit_mark1();
    exp_sync = 1;
    compare_all("partial byte");

    // short glitch is filtered out
    drive(2'b10, FILT - 1);
    drive(2'b11, hold());
    chk("glitch no state change", n_not_stop, 0);
    compare_all("glitch");

    // 11 -> 00 directly, then recovery
    drive(2'b00, hold());
    drive(2'b11, hold());
    exp_esc = 1;
    compare_all("direct 00");
    entry();
    send_byte(8'h87);
    exp_cmd.push_back(8'h87);
    d = 8'($urandom);
    send_byte(d); exp_rx.push_back(d);
    exit_mark1();
    compare_all("recovery");

    // mark 10 -> 01 without a space
    entry();
    drive(2'b10, hold());
    drive(2'b01, hold());
    drive(2'b11, hold());
    exp_esc = 1;
    compare_all("mark to mark");

    // reset in the middle of an LPDT byte
    entry();
    send_byte(8'h87);
    send_byte(8'h5A);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    drive(2'b10, 3);
    rst = 1'b1;
    lp_p = 1'b1; lp_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("mid-byte reset outputs", {rx_data, rx_valid, cmd, cmd_valid, lpdt_active, ulps_active,
                                   trigger, stop_state, err_esc, err_sync}, 24'h000004);
    clear_all();
    rst = 1'b0;
    drive(2'b11, hold());
    compare_all("after reset");
    entry();
    send_byte(8'h87);
    exp_cmd.push_back(8'h87);
    d = 8'($urandom);
    send_byte(d); exp_rx.push_back(d);
    exit_mark1();
    compare_all("post reset entry");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
